reg_file_rw: RTL and testbench
==============================

// Module: reg_file_rw
// PURPOSE
//  Parametrised 2-read/1-write register file for the MIPS datapath; next generation of the fixed-table RF.
//  Async reset loads a preset table; synchronous writes thereafter; per-register pending scoreboard for hazard detection.
//  Sits between decode (read ports, reservations) and writeback (write port).
// PARAMETERS
//  DATA_W    32  register width in bits
//  NUM_REGS  32  register count, power of two, 2..32; ADDR_W = $clog2(NUM_REGS)
//  ZERO_REG  1   1: register 0 reads 0 and ignores writes/reservations; 0: register 0 is ordinary
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       asynchronous, active-high reset
//  Address1  in   ADDR_W  read port 1 address
//  Address2  in   ADDR_W  read port 2 address
//  Source1   out  DATA_W  read port 1 data
//  Source2   out  DATA_W  read port 2 data
//  Busy1     out  1       pending bit of Address1
//  Busy2     out  1       pending bit of Address2
//  wr_en     in   1       write strobe
//  wr_addr   in   ADDR_W  write address
//  wr_data   in   DATA_W  write data
//  rsv_en    in   1       reserve: mark rsv_addr pending (producer issued)
//  rsv_addr  in   ADDR_W  register to reserve
// BEHAVIOUR
//  Reset (async, rst=1): reg[i] <= rf_init_value(i) truncated/zero-extended to DATA_W; all pending bits 0.
//   rst mid-write: write lost, table values restored. Source*/Busy* follow the reset contents immediately.
//  Reads: combinational, zero latency; Source = reg[Address], Busy = pend[Address].
//  Write: on posedge with wr_en=1, reg[wr_addr] <= wr_data, pend[wr_addr] <= 0. Visible to reads next cycle.
//  Reserve: on posedge with rsv_en=1, pend[rsv_addr] <= 1.
//  Same-edge wr_en and rsv_en, same address: data written AND pend stays 1 (new producer wins).
//  Same-edge, different addresses: both take effect independently.
//  Write to non-pending register: legal, data written, pend stays 0.
//  ZERO_REG=1: Source/Busy for address 0 are 0; writes/reservations to 0 dropped; reset value of reg[0] is 0.
//  Address1 == Address2: both ports return identical values.
//  No arithmetic; addresses are full-range (NUM_REGS is a power of two), no out-of-range case.
// CONFIGURATION
//  RF_BYPASS_EN defined: write-through bypass; if wr_en && Address==wr_addr (and not suppressed by ZERO_REG),
//   Source = wr_data and Busy = (rsv_en && rsv_addr==Address) in the same cycle.
//  RF_BYPASS_EN undefined: reads return stored state only; written data visible the following cycle.
// STRUCTURE
//  rf_pkg: function rf_init_value(int idx) returning preset table, 0 for idx>=32:
//   0:21 1:444 2:178 3:365 4:33 5:89 6:49 7:11 8:347 9:44 10:1000 11:2000 12:71 13:38 14:19 15:51
//   16:663 17:1871 18:364 19:1110 20:197 21:180 22:1 23:619 24:42 25:43 26:831 27:39 28:734 29:92 30:3456 31:1234
//  Sub-module rf_read_port (instantiated twice): address mux, ZERO_REG masking, optional bypass, busy lookup.
//  Storage array and pend vector live in the top; no other sub-modules.
// TESTING
//  1. Assert rst, Address1=10, Address2=31 -> Source1=1000, Source2=1234, Busy1=Busy2=0 (ZERO_REG=0).
//  2. ZERO_REG=1: wr_en, wr_addr=0, wr_data=0xDEAD, then Address1=0 -> Source1=0; rsv_addr=0 -> Busy1=0.
//  3. rsv_en addr 5; next cycle Address1=5 -> Busy1=1, Source1=89; wr_en addr 5 data 77 -> next cycle Busy1=0, Source1=77.
//  4. Same edge rsv_en+wr_en addr 7 data 0x55 -> next cycle Source=0x55, Busy=1.
//  5. wr_en addr 3 data 0xABCD with Address2=3 in same cycle -> Source2=0xABCD same cycle iff RF_BYPASS_EN, else 365 then 0xABCD.
//  6. Write addr 12 data 9, reserve addr 13, then rst pulse mid-cycle -> Source(12)=71, Busy(13)=0 immediately.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the reg_file_rw register file: preset reset table and
// table geometry. The optional bypass is selected with the RF_BYPASS_EN macro.
package rf_pkg;

  localparam int RF_TABLE_SIZE = 32;
  localparam int RF_TABLE_W    = 32;

  typedef enum logic [0:0] {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } rf_port_e;

  function automatic logic [RF_TABLE_W-1:0] rf_init_value(input int idx);
    logic [RF_TABLE_W-1:0] val;
    case (idx)
      0:  val = 32'd21;
      1:  val = 32'd444;
      2:  val = 32'd178;
      3:  val = 32'd365;
      4:  val = 32'd33;
      5:  val = 32'd89;
      6:  val = 32'd49;
      7:  val = 32'd11;
      8:  val = 32'd347;
      9:  val = 32'd44;
      10: val = 32'd1000;
      11: val = 32'd2000;
      12: val = 32'd71;
      13: val = 32'd38;
      14: val = 32'd19;
      15: val = 32'd51;
      16: val = 32'd663;
      17: val = 32'd1871;
      18: val = 32'd364;
      19: val = 32'd1110;
      20: val = 32'd197;
      21: val = 32'd180;
      22: val = 32'd1;
      23: val = 32'd619;
      24: val = 32'd42;
      25: val = 32'd43;
      26: val = 32'd831;
      27: val = 32'd39;
      28: val = 32'd734;
      29: val = 32'd92;
      30: val = 32'd3456;
      31: val = 32'd1234;
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register/pending lookup, register-0 masking and,
// when RF_BYPASS_EN is defined, write-through forwarding of the same-cycle write.
module rf_read_port
  import rf_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [DATA_W-1:0]   regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] pend,
  input  logic [ADDR_W-1:0]   rd_addr,
`ifdef RF_BYPASS_EN
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
`endif
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_busy
);

  logic zero_hit;

  always_comb begin
    zero_hit = (ZERO_REG != 0) && (rd_addr == '0);
    rd_data  = regs[rd_addr];
    rd_busy  = pend[rd_addr];
`ifdef RF_BYPASS_EN
    // Reset has priority: while rst is high the port shows the restored table.
    if (!rst && wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
      rd_busy = rsv_en && (rsv_addr == rd_addr);
    end
`endif
    if (zero_hit) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_rw.sv
// 2-read/1-write register file with preset reset table and per-register pending
// scoreboard. Define RF_BYPASS_EN for write-through forwarding on the read ports.
module reg_file_rw
  import rf_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Address1,
  input  logic [ADDR_W-1:0] Address2,
  output logic [DATA_W-1:0] Source1,
  output logic [DATA_W-1:0] Source2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr
);

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic                wr_ok;
  logic                rsv_ok;

  always_comb begin
    wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_ok) begin
      mem_d[wr_addr]  = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    // Applied after the write so a same-edge reservation keeps the bit set.
    if (rsv_ok) begin
      pend_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0 : DATA_W'(rf_init_value(i));
      end
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign rd_addr[PORT_A] = Address1;
  assign rd_addr[PORT_B] = Address2;
  assign Source1 = rd_data[PORT_A];
  assign Source2 = rd_data[PORT_B];
  assign Busy1   = rd_busy[PORT_A];
  assign Busy2   = rd_busy[PORT_B];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
      ) u_port (
        .regs     (mem_q),
        .pend     (pend_q),
        .rd_addr  (rd_addr[gi]),
`ifdef RF_BYPASS_EN
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
`endif
        .rd_data  (rd_data[gi]),
        .rd_busy  (rd_busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_rw.sv
// Bench for reg_file_rw: one instance with ZERO_REG=0 and one with ZERO_REG=1
// share the stimulus; expectations come from a table and from a reference model.
module tb_reg_file_rw;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] a1 = '0, a2 = '0, wa = '0, ra = '0;
  logic [DW-1:0] wd = '0;
  logic          we = 1'b0, re = 1'b0;
  logic [DW-1:0] s1_0, s2_0, s1_1, s2_1;
  logic          b1_0, b2_0, b1_1, b2_1;

  always #5 clk = ~clk;

  reg_file_rw #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .Address1(a1), .Address2(a2),
    .Source1(s1_0), .Source2(s2_0), .Busy1(b1_0), .Busy2(b2_0),
    .wr_en(we), .wr_addr(wa), .wr_data(wd), .rsv_en(re), .rsv_addr(ra));

  reg_file_rw #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst), .Address1(a1), .Address2(a2),
    .Source1(s1_1), .Source2(s2_1), .Busy1(b1_1), .Busy2(b2_1),
    .wr_en(we), .wr_addr(wa), .wr_data(wd), .rsv_en(re), .rsv_addr(ra));

  int checks   = 0;
  int failures = 0;

  logic [31:0] init_tab [32] = '{
    32'd21, 32'd444, 32'd178, 32'd365, 32'd33, 32'd89, 32'd49, 32'd11,
    32'd347, 32'd44, 32'd1000, 32'd2000, 32'd71, 32'd38, 32'd19, 32'd51,
    32'd663, 32'd1871, 32'd364, 32'd1110, 32'd197, 32'd180, 32'd1, 32'd619,
    32'd42, 32'd43, 32'd831, 32'd39, 32'd734, 32'd92, 32'd3456, 32'd1234};

  logic [31:0] m [2][32];
  logic        p [2][32];

  typedef struct {
    logic [31:0] s1a, s2a, s1b, s2b;
    logic        b1a, b2a, b1b, b2b;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2;
    logic        eb1, eb2;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < 32; i++) begin
        m[z][i] = (z == 1 && i == 0) ? 32'd0 : init_tab[i];
        p[z][i] = 1'b0;
      end
  endtask

  task automatic mread(input int z, input logic [4:0] a, output logic [31:0] d, output logic b);
    d = m[z][a];
    b = p[z][a];
`ifdef RF_BYPASS_EN
    if (we && wa == a && !(z == 1 && a == 0)) begin
      d = wd;
      b = re && (ra == a);
    end
`endif
    if (z == 1 && a == 0) begin
      d = 32'd0;
      b = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      if (we && !(z == 1 && wa == 0)) begin
        m[z][wa] = wd;
        p[z][wa] = 1'b0;
      end
      if (re && !(z == 1 && ra == 0)) p[z][ra] = 1'b1;
    end
  endtask

  task automatic push_model();
    exp_t e;
    mread(0, a1, e.s1a, e.b1a);
    mread(0, a2, e.s2a, e.b2a);
    mread(1, a1, e.s1b, e.b1b);
    mread(1, a2, e.s2b, e.b2b);
    sb.push_back(e);
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard_empty actual=0 required=1", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_z0_src1"}, s1_0, e.s1a);
    chk({tag, "_z0_src2"}, s2_0, e.s2a);
    chk({tag, "_z0_busy1"}, {31'd0, b1_0}, {31'd0, e.b1a});
    chk({tag, "_z0_busy2"}, {31'd0, b2_0}, {31'd0, e.b2a});
    chk({tag, "_z1_src1"}, s1_1, e.s1b);
    chk({tag, "_z1_src2"}, s2_1, e.s2b);
    chk({tag, "_z1_busy1"}, {31'd0, b1_1}, {31'd0, e.b1b});
    chk({tag, "_z1_busy2"}, {31'd0, b2_1}, {31'd0, e.b2b});
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0;
  endtask

  initial begin
    exp_t e;

    vt[0]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd5,  5'd5,  5'd7,  32'd89,     32'd11,     1'b0, 1'b0};
    vt[1]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd5,  5'd5,  32'd89,     32'd89,     1'b1, 1'b1};
    vt[2]  = '{1'b1, 5'd5,  32'd77,   1'b0, 5'd0,  5'd6,  5'd7,  32'd49,     32'd11,     1'b0, 1'b0};
    vt[3]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd5,  5'd6,  32'd77,     32'd49,     1'b0, 1'b0};
    vt[4]  = '{1'b1, 5'd7,  32'h55,   1'b1, 5'd7,  5'd8,  5'd9,  32'd347,    32'd44,     1'b0, 1'b0};
    vt[5]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd7,  5'd7,  32'h55,     32'h55,     1'b1, 1'b1};
    vt[6]  = '{1'b1, 5'd20, 32'h1234, 1'b1, 5'd21, 5'd22, 5'd23, 32'd1,      32'd619,    1'b0, 1'b0};
    vt[7]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd20, 5'd21, 32'h1234,   32'd180,    1'b0, 1'b1};
    vt[8]  = '{1'b1, 5'd21, 32'd5,    1'b0, 5'd0,  5'd0,  5'd1,  32'd21,     32'd444,    1'b0, 1'b0};
    vt[9]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd21, 5'd20, 32'd5,      32'h1234,   1'b0, 1'b0};
    vt[10] = '{1'b1, 5'd0,  32'hDEAD, 1'b1, 5'd0,  5'd2,  5'd3,  32'd178,    32'd365,    1'b0, 1'b0};
    vt[11] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd0,  5'd0,  32'hDEAD,   32'hDEAD,   1'b1, 1'b1};

    // Reset state
    a1 = 5'd10; a2 = 5'd31;
    #2 rst = 1'b1;
    #1;
    chk("rst_z0_src1", s1_0, 32'd1000);
    chk("rst_z0_src2", s2_0, 32'd1234);
    chk("rst_z0_busy1", {31'd0, b1_0}, 32'd0);
    chk("rst_z0_busy2", {31'd0, b2_0}, 32'd0);
    chk("rst_z1_src1", s1_1, 32'd1000);
    a1 = 5'd0;
    #1;
    chk("rst_z0_reg0", s1_0, 32'd21);
    chk("rst_z1_reg0", s1_1, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
      re = vt[i].re; ra = vt[i].ra; a1 = vt[i].a1; a2 = vt[i].a2;
      e.s1a = vt[i].e1;  e.s2a = vt[i].e2;  e.b1a = vt[i].eb1; e.b2a = vt[i].eb2;
      e.s1b = (vt[i].a1 == 0) ? 32'd0 : vt[i].e1;
      e.s2b = (vt[i].a2 == 0) ? 32'd0 : vt[i].e2;
      e.b1b = (vt[i].a1 == 0) ? 1'b0 : vt[i].eb1;
      e.b2b = (vt[i].a2 == 0) ? 1'b0 : vt[i].eb2;
      sb.push_back(e);
      @(negedge clk);
      compare_pop($sformatf("vec%0d", i));
      @(posedge clk); #1;
    end
    idle();

    // Write with concurrent read of the same register
    we = 1'b1; wa = 5'd3; wd = 32'hABCD; a1 = 5'd4; a2 = 5'd3;
    @(negedge clk);
`ifdef RF_BYPASS_EN
    chk("wt_same_cycle_src2", s2_0, 32'hABCD);
`else
    chk("wt_same_cycle_src2", s2_0, 32'd365);
`endif
    chk("wt_same_cycle_busy2", {31'd0, b2_0}, 32'd0);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("wt_next_cycle_src2", s2_0, 32'hABCD);
    chk("wt_next_cycle_z1_src2", s2_1, 32'hABCD);

    // Write plus reservation on the register being read
    @(posedge clk); #1;
    we = 1'b1; wa = 5'd6; wd = 32'h66; re = 1'b1; ra = 5'd6; a1 = 5'd6;
    @(negedge clk);
`ifdef RF_BYPASS_EN
    chk("wr_rsv_same_src1", s1_0, 32'h66);
    chk("wr_rsv_same_busy1", {31'd0, b1_0}, 32'd1);
`else
    chk("wr_rsv_same_src1", s1_0, 32'd49);
    chk("wr_rsv_same_busy1", {31'd0, b1_0}, 32'd0);
`endif
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("wr_rsv_next_src1", s1_0, 32'h66);
    chk("wr_rsv_next_busy1", {31'd0, b1_0}, 32'd1);

    // Reset pulse in the middle of a cycle, then a write held under reset
    @(posedge clk); #1;
    we = 1'b1; wa = 5'd12; wd = 32'd9; re = 1'b1; ra = 5'd13; a1 = 5'd12; a2 = 5'd13;
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("pre_rst_src1", s1_0, 32'd9);
    chk("pre_rst_busy2", {31'd0, b2_0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_src1", s1_0, 32'd71);
    chk("mid_rst_busy2", {31'd0, b2_0}, 32'd0);
    chk("mid_rst_src2", s2_0, 32'd38);
    we = 1'b1; wa = 5'd12; wd = 32'h99;
    @(posedge clk); #1;
    chk("rst_write_lost_src1", s1_0, 32'd71);
    chk("rst_write_lost_z1_src1", s1_1, 32'd71);
    idle();
    @(posedge clk); #1 rst = 1'b0;
    model_reset();

    // Randomised traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 2) == 0);
      wa = 5'($urandom_range(0, (n % 2) ? 31 : 7));
      ra = 5'($urandom_range(0, 7));
      a1 = 5'($urandom_range(0, 7));
      a2 = 5'($urandom_range(0, (n % 3) ? 7 : 31));
      wd = $urandom;
      push_model();
      @(negedge clk);
      compare_pop($sformatf("rnd%0d", n));
      model_edge();
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
